// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Pipeline sequencing controller for a 5-stage RV32IM core. Every cycle it
//   decides which pipeline registers advance, hold or take a bubble. Inputs
//   are load-use hazards, multi-cycle mul/div operations in EXE, data-memory
//   wait states and taken branches.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   id_addr1/2, id_uses_rs1/2  source registers of the ID instruction
//   id_store                   ID instruction is a store (rs2 = store data)
//   exe_addr, exe_mem_read     rd of the EXE instruction, EXE is a load
//   exe_muldiv_start           first EXE cycle of a MUL/DIV/REM
//   muldiv_done                mul/div result valid this cycle
//   branch_taken               EXE resolved a taken branch/jump
//   dmem_busy                  data memory not ready, MEM must hold
//   *_write_en                 pipeline register advance enables
//   *_flush                    load a NOP into the register (beats hold)
//   state                      RUN=0, MULDIV_WAIT=1, MEM_WAIT=2, MEM_WAIT_MD=3
//   stall_count                saturating count of cycles with pc_write_en=0
//   muldiv_timeout             sticky, set when a mul/div wait is force-released
//
// state        | meaning
// -------------+-------------------------------------------------------------
// RUN          | normal flow; branch flush and load-use bubble handled here
// MULDIV_WAIT  | mul/div in EXE, front end held, bubbles into EXE/MEM
// MEM_WAIT     | data memory busy with no mul/div outstanding
// MEM_WAIT_MD  | data memory busy while a mul/div is outstanding

module hazard_stall_controller #(
  parameter int unsigned MULDIV_MAX_CYCLES = 40,
  parameter int unsigned STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_addr1,
  input  logic [4:0]             id_addr2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   id_store,
  input  logic [4:0]             exe_addr,
  input  logic                   exe_mem_read,
  input  logic                   exe_muldiv_start,
  input  logic                   muldiv_done,
  input  logic                   branch_taken,
  input  logic                   dmem_busy,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   id_exe_write_en,
  output logic                   exe_mem_write_en,
  output logic                   mem_wb_write_en,
  output logic                   if_id_flush,
  output logic                   id_exe_flush,
  output logic                   exe_mem_flush,
  output logic                   mem_wb_flush,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   muldiv_timeout
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MULDIV_WAIT = 2'd1,
    MEM_WAIT    = 2'd2,
    MEM_WAIT_MD = 2'd3
  } state_t;

  // Down-counter of remaining MULDIV_WAIT cycles; reaching zero without
  // done means the mul/div has overrun its budget.
  localparam int unsigned WAIT_W = $clog2(MULDIV_MAX_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULDIV_MAX_CYCLES - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;
  logic              timeout_set;
  logic              load_use;

  // Store data (rs2 of a store) is forwarded in MEM, so it never needs a bubble.
  assign load_use = exe_mem_read && (exe_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_addr1 == exe_addr)) ||
                     (id_uses_rs2 && !id_store && (id_addr2 == exe_addr)));

  assign state = state_q;

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    pend_d           = 1'b0;
    timeout_set      = 1'b0;
    pc_write_en      = 1'b1;
    if_id_write_en   = 1'b1;
    id_exe_write_en  = 1'b1;
    exe_mem_write_en = 1'b1;
    mem_wb_write_en  = 1'b1;
    if_id_flush      = 1'b0;
    id_exe_flush     = 1'b0;
    exe_mem_flush    = 1'b0;
    mem_wb_flush     = 1'b0;

    if (reset) begin
      pc_write_en      = 1'b0;
      if_id_write_en   = 1'b0;
      id_exe_write_en  = 1'b0;
      exe_mem_write_en = 1'b0;
      mem_wb_write_en  = 1'b0;
      if_id_flush      = 1'b1;
      id_exe_flush     = 1'b1;
      exe_mem_flush    = 1'b1;
      mem_wb_flush     = 1'b1;
      state_d          = RUN;
    end else begin
      unique case (state_q)
        // MEM_WAIT shares RUN's decision: while busy it re-enters MEM_WAIT,
        // and once memory is ready the same cycle is evaluated as RUN.
        RUN, MEM_WAIT: begin
          if (dmem_busy) begin
            pc_write_en      = 1'b0;
            if_id_write_en   = 1'b0;
            id_exe_write_en  = 1'b0;
            exe_mem_write_en = 1'b0;
            mem_wb_write_en  = 1'b0;
            mem_wb_flush     = 1'b1;
            state_d          = MEM_WAIT;
          end else if (exe_muldiv_start && !muldiv_done) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_exe_write_en = 1'b0;
            exe_mem_flush   = 1'b1;
            wait_d          = WAIT_LAST;
            state_d         = MULDIV_WAIT;
          end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
            state_d      = RUN;
          end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_exe_flush   = 1'b1;
            state_d        = RUN;
          end else begin
            state_d = RUN;
          end
        end

        MULDIV_WAIT: begin
          if (wait_q != '0) wait_d = wait_q - 1'b1;
          if (muldiv_done && !dmem_busy) begin
            state_d = RUN;
          end else if (dmem_busy) begin
            pc_write_en      = 1'b0;
            if_id_write_en   = 1'b0;
            id_exe_write_en  = 1'b0;
            exe_mem_write_en = 1'b0;
            mem_wb_write_en  = 1'b0;
            mem_wb_flush     = 1'b1;
            pend_d           = muldiv_done;
            state_d          = MEM_WAIT_MD;
          end else if (wait_q == '0) begin
            timeout_set = 1'b1;
            state_d     = RUN;
          end else begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_exe_write_en = 1'b0;
            exe_mem_flush   = 1'b1;
          end
        end

        MEM_WAIT_MD: begin
          if (dmem_busy) begin
            pc_write_en      = 1'b0;
            if_id_write_en   = 1'b0;
            id_exe_write_en  = 1'b0;
            exe_mem_write_en = 1'b0;
            mem_wb_write_en  = 1'b0;
            mem_wb_flush     = 1'b1;
            pend_d           = pend_q || muldiv_done;
          end else if (pend_q || muldiv_done) begin
            state_d = RUN;
          end else begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_exe_write_en = 1'b0;
            exe_mem_flush   = 1'b1;
            state_d         = MULDIV_WAIT;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_q         <= '0;
      pend_q         <= 1'b0;
      muldiv_timeout <= 1'b0;
      stall_count    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      if (timeout_set) muldiv_timeout <= 1'b1;
      if (!pc_write_en && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_addr1, id_addr2, exe_addr;
  logic        id_uses_rs1, id_uses_rs2, id_store;
  logic        exe_mem_read, exe_muldiv_start, muldiv_done, branch_taken, dmem_busy;
  logic        pc_write_en, if_id_write_en, id_exe_write_en, exe_mem_write_en, mem_wb_write_en;
  logic        if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        muldiv_timeout;

  logic [4:0]  en;
  logic [3:0]  fl;
  int          checks = 0;
  int          errors = 0;

  assign en = {pc_write_en, if_id_write_en, id_exe_write_en, exe_mem_write_en, mem_wb_write_en};
  assign fl = {if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush};

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULDIV_MAX_CYCLES(40), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_addr1(id_addr1), .id_addr2(id_addr2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_store(id_store),
    .exe_addr(exe_addr), .exe_mem_read(exe_mem_read),
    .exe_muldiv_start(exe_muldiv_start), .muldiv_done(muldiv_done),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_exe_write_en(id_exe_write_en), .exe_mem_write_en(exe_mem_write_en),
    .mem_wb_write_en(mem_wb_write_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_flush(exe_mem_flush), .mem_wb_flush(mem_wb_flush),
    .state(state), .stall_count(stall_count), .muldiv_timeout(muldiv_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [1:0] st, input logic [4:0] e, input logic [3:0] f);
    chk({tag, "/state"}, 32'(state), 32'(st));
    chk({tag, "/en"},    32'(en),    32'(e));
    chk({tag, "/flush"}, 32'(fl),    32'(f));
  endtask

  task automatic cnt(input string tag, input logic [15:0] c, input logic t);
    chk({tag, "/stall_count"}, 32'(stall_count),    32'(c));
    chk({tag, "/timeout"},     32'(muldiv_timeout), 32'(t));
  endtask

  // Advance to the next cycle's input phase with all inputs idle.
  task automatic cyc();
    @(negedge clk);
    id_addr1 = 5'd0; id_addr2 = 5'd0; exe_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_store = 1'b0;
    exe_mem_read = 1'b0; exe_muldiv_start = 1'b0; muldiv_done = 1'b0;
    branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_addr1 = 5'd0; id_addr2 = 5'd0; exe_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_store = 1'b0;
    exe_mem_read = 1'b0; exe_muldiv_start = 1'b0; muldiv_done = 1'b0;
    branch_taken = 1'b0; dmem_busy = 1'b0;

    // power-on reset, two edges
    cyc(); #1; ctl("por", 2'd0, 5'b00000, 4'b1111);
    cyc(); reset = 1'b0; #1;
    ctl("por_after", 2'd0, 5'b11111, 4'b0000); cnt("por_after", 16'd0, 1'b0);

    // load-use on rs1: one bubble
    cyc(); exe_mem_read = 1'b1; exe_addr = 5'd5; id_addr1 = 5'd5; id_uses_rs1 = 1'b1; #1;
    ctl("lu_rs1", 2'd0, 5'b00111, 4'b0100);
    cyc(); #1; ctl("lu_rs1_next", 2'd0, 5'b11111, 4'b0000); cnt("lu_rs1_next", 16'd1, 1'b0);

    // load to x0 never stalls
    cyc(); exe_mem_read = 1'b1; exe_addr = 5'd0; id_addr1 = 5'd0; id_uses_rs1 = 1'b1; #1;
    ctl("lu_x0", 2'd0, 5'b11111, 4'b0000);

    // store data on rs2 is forwarded later: no stall
    cyc(); exe_mem_read = 1'b1; exe_addr = 5'd7; id_addr2 = 5'd7; id_uses_rs2 = 1'b1; id_store = 1'b1; #1;
    ctl("lu_store", 2'd0, 5'b11111, 4'b0000);

    // same rs2 match on a non-store does stall
    cyc(); exe_mem_read = 1'b1; exe_addr = 5'd7; id_addr2 = 5'd7; id_uses_rs2 = 1'b1; #1;
    ctl("lu_rs2", 2'd0, 5'b00111, 4'b0100);
    cyc(); #1; cnt("lu_rs2_next", 16'd2, 1'b0);

    // branch wins over load-use, not counted
    cyc(); exe_mem_read = 1'b1; exe_addr = 5'd5; id_addr1 = 5'd5; id_uses_rs1 = 1'b1; branch_taken = 1'b1; #1;
    ctl("br_lu", 2'd0, 5'b11111, 4'b1100);
    cyc(); #1; cnt("br_lu_next", 16'd2, 1'b0);

    // DIV: start cycle 0, done cycle 33
    cyc(); exe_muldiv_start = 1'b1; #1; ctl("div_c0", 2'd0, 5'b00011, 4'b0010);
    for (int i = 1; i <= 32; i++) begin
      cyc(); #1; ctl($sformatf("div_c%0d", i), 2'd1, 5'b00011, 4'b0010);
    end
    cyc(); muldiv_done = 1'b1; #1; ctl("div_c33", 2'd1, 5'b11111, 4'b0000);
    cyc(); #1; ctl("div_c34", 2'd0, 5'b11111, 4'b0000); cnt("div_c34", 16'd35, 1'b0);

    // DIV with memory busy cycles 10-14, done pulsed at 12
    cyc(); exe_muldiv_start = 1'b1; #1; ctl("dm_c0", 2'd0, 5'b00011, 4'b0010);
    for (int i = 1; i <= 9; i++) begin
      cyc(); #1; ctl($sformatf("dm_c%0d", i), 2'd1, 5'b00011, 4'b0010);
    end
    cyc(); dmem_busy = 1'b1; #1; ctl("dm_c10", 2'd1, 5'b00000, 4'b0001);
    for (int i = 11; i <= 14; i++) begin
      cyc(); dmem_busy = 1'b1; muldiv_done = (i == 12); #1;
      chk($sformatf("dm_c%0d/state", i), 32'(state), 32'd3);
      chk($sformatf("dm_c%0d/en", i), 32'(en), 32'd0);
    end
    cyc(); #1; ctl("dm_c15", 2'd3, 5'b11111, 4'b0000);
    cyc(); #1; ctl("dm_c16", 2'd0, 5'b11111, 4'b0000); cnt("dm_c16", 16'd50, 1'b0);

    // done together with start: no stall
    cyc(); exe_muldiv_start = 1'b1; muldiv_done = 1'b1; #1; ctl("md_same", 2'd0, 5'b11111, 4'b0000);
    cyc(); #1; cnt("md_same_next", 16'd50, 1'b0);

    // no done: forced release after 40 held cycles
    cyc(); exe_muldiv_start = 1'b1; #1; ctl("to_c0", 2'd0, 5'b00011, 4'b0010);
    for (int i = 1; i <= 39; i++) begin
      cyc(); #1;
      chk($sformatf("to_c%0d/en", i), 32'(en), 32'b00011);
    end
    chk("to_c39/timeout", 32'(muldiv_timeout), 32'd0);
    cyc(); #1; ctl("to_c40", 2'd1, 5'b11111, 4'b0000);
    cyc(); #1; ctl("to_c41", 2'd0, 5'b11111, 4'b0000); cnt("to_c41", 16'd90, 1'b1);

    // MEM_WAIT, then ready cycle evaluated as RUN with a load-use
    cyc(); dmem_busy = 1'b1; #1; ctl("mw_a", 2'd0, 5'b00000, 4'b0001);
    cyc(); dmem_busy = 1'b1; #1; ctl("mw_b", 2'd2, 5'b00000, 4'b0001);
    cyc(); exe_mem_read = 1'b1; exe_addr = 5'd9; id_addr1 = 5'd9; id_uses_rs1 = 1'b1; #1;
    ctl("mw_c", 2'd2, 5'b00111, 4'b0100);
    cyc(); #1; ctl("mw_d", 2'd0, 5'b11111, 4'b0000); cnt("mw_d", 16'd93, 1'b1);

    // reset for two cycles in the middle of MULDIV_WAIT
    cyc(); exe_muldiv_start = 1'b1; #1;
    cyc(); #1;
    cyc(); #1; chk("rst_pre/state", 32'(state), 32'd1);
    cyc(); reset = 1'b1; #1; ctl("rst_c0", 2'd1, 5'b00000, 4'b1111);
    cyc(); reset = 1'b1; #1; ctl("rst_c1", 2'd0, 5'b00000, 4'b1111);
    cyc(); reset = 1'b0; #1;
    ctl("rst_after", 2'd0, 5'b11111, 4'b0000); cnt("rst_after", 16'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
